// File: rtl/rxiod_lane_align_sequencer.sv
// Sequences RX IOD bit-alignment training lane by lane: restart pulse, wait for
// DONE/ERR/OOR or timeout, retry failed lanes, freeze passed lanes via HOLD.
module rxiod_lane_align_sequencer #(
  parameter int NUM_LANES   = 4,
  parameter int LANE_IDX_W  = 2,
  parameter int TIMEOUT_W   = 16,
  parameter int TIMEOUT_CYC = 50000,
  parameter int MAX_RETRY   = 3,
  parameter int RSTRT_PULSE = 4
) (
  input  logic                  SCLK,
  input  logic                  RESETN,
  input  logic                  PLL_LOCK,
  input  logic                  TRAIN_REQ,
  input  logic [NUM_LANES-1:0]  BIT_ALGN_DONE,
  input  logic [NUM_LANES-1:0]  BIT_ALGN_ERR,
  input  logic [NUM_LANES-1:0]  BIT_ALGN_OOR,
  output logic [NUM_LANES-1:0]  BIT_ALGN_RSTRT,
  output logic [NUM_LANES-1:0]  BIT_ALGN_HOLD,
  output logic [NUM_LANES-1:0]  LANE_OK,
  output logic [LANE_IDX_W-1:0] ACTIVE_LANE,
  output logic                  ALIGN_BUSY,
  output logic                  ALIGN_DONE,
  output logic                  ALIGN_FAIL,
  output logic [LANE_IDX_W-1:0] FAIL_LANE,
  output logic [2:0]            state_dbg
);

  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [TIMEOUT_W-1:0]  TIMER_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);
  localparam logic [RETRY_W-1:0]    RETRY_MAX  = RETRY_W'(MAX_RETRY);
  localparam logic [LANE_IDX_W-1:0] LANE_LAST  = LANE_IDX_W'(NUM_LANES - 1);
  localparam logic [3:0]            PULSE_LAST = 4'(RSTRT_PULSE - 1);

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_RSTRT     = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_ALIGNED   = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [LANE_IDX_W-1:0]   lane_q, lane_d;
  logic [RETRY_W-1:0]      retry_q, retry_d;
  logic [TIMEOUT_W-1:0]    timer_q, timer_d;
  logic                    dsl_q, dsl_d;
  logic [3:0]              pcnt_q, pcnt_d;
  logic [NUM_LANES-1:0]    rstrt_q, rstrt_d;
  logic [NUM_LANES-1:0]    hold_q, hold_d;
  logic [NUM_LANES-1:0]    ok_q, ok_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    fail_q, fail_d;
  logic [LANE_IDX_W-1:0]   fail_lane_q, fail_lane_d;
  logic                    treq_q;

  logic                    train_rise;
  logic                    cur_done, cur_err, cur_oor;
  logic                    fail_evt, pass_evt;

  function automatic logic [NUM_LANES-1:0] lane_bit(input logic [LANE_IDX_W-1:0] idx);
    lane_bit      = '0;
    lane_bit[idx] = 1'b1;
  endfunction

  always_ff @(posedge SCLK) begin
    if (!RESETN) begin
      state_q     <= ST_WAIT_LOCK;
      lane_q      <= '0;
      retry_q     <= '0;
      timer_q     <= '0;
      dsl_q       <= 1'b0;
      pcnt_q      <= '0;
      rstrt_q     <= '0;
      hold_q      <= '0;
      ok_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_lane_q <= '0;
      treq_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      retry_q     <= retry_d;
      timer_q     <= timer_d;
      dsl_q       <= dsl_d;
      pcnt_q      <= pcnt_d;
      rstrt_q     <= rstrt_d;
      hold_q      <= hold_d;
      ok_q        <= ok_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_lane_q <= fail_lane_d;
      treq_q      <= TRAIN_REQ;
    end
  end

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    retry_d     = retry_q;
    timer_d     = timer_q;
    dsl_d       = dsl_q;
    pcnt_d      = pcnt_q;
    rstrt_d     = rstrt_q;
    hold_d      = hold_q;
    ok_d        = ok_q;
    busy_d      = busy_q;
    done_d      = done_q;
    fail_d      = fail_q;
    fail_lane_d = fail_lane_q;

    train_rise = TRAIN_REQ & ~treq_q;
    cur_done   = BIT_ALGN_DONE[lane_q];
    cur_err    = BIT_ALGN_ERR[lane_q];
    cur_oor    = BIT_ALGN_OOR[lane_q];
    // DONE only counts once it has been seen low in this attempt, so a level
    // left over from a previous run cannot pass the lane.
    pass_evt   = cur_done & dsl_q & ~cur_err & ~cur_oor;
    fail_evt   = (cur_done & dsl_q & (cur_err | cur_oor)) | cur_err |
                 (timer_q == TIMER_LAST);

    if ((state_q != ST_WAIT_LOCK) && (!PLL_LOCK || train_rise)) begin
      // Lock loss and retrain share one abort; any pulse in flight is cut short.
      state_d     = ST_WAIT_LOCK;
      lane_d      = '0;
      retry_d     = '0;
      timer_d     = '0;
      dsl_d       = 1'b0;
      pcnt_d      = '0;
      rstrt_d     = '0;
      hold_d      = '0;
      ok_d        = '0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      fail_d      = 1'b0;
      fail_lane_d = '0;
    end else begin
      case (state_q)
        ST_WAIT_LOCK: begin
          if (PLL_LOCK) begin
            state_d = ST_RSTRT;
            lane_d  = '0;
            retry_d = '0;
            rstrt_d = lane_bit('0);
            pcnt_d  = PULSE_LAST;
            busy_d  = 1'b1;
          end
        end
        ST_RSTRT: begin
          if (pcnt_q == 4'd0) begin
            state_d = ST_WAIT_DONE;
            rstrt_d = '0;
            timer_d = '0;
            dsl_d   = 1'b0;
          end else begin
            pcnt_d = pcnt_q - 4'd1;
          end
        end
        ST_WAIT_DONE: begin
          timer_d = timer_q + TIMEOUT_W'(1);
          if (!cur_done) dsl_d = 1'b1;
          if (fail_evt) begin
            if (retry_q < RETRY_MAX) begin
              state_d = ST_RSTRT;
              retry_d = retry_q + RETRY_W'(1);
              rstrt_d = lane_bit(lane_q);
              pcnt_d  = PULSE_LAST;
            end else begin
              state_d     = ST_FAIL;
              fail_d      = 1'b1;
              fail_lane_d = lane_q;
              busy_d      = 1'b0;
            end
          end else if (pass_evt) begin
            ok_d[lane_q]   = 1'b1;
            hold_d[lane_q] = 1'b1;
            if (lane_q == LANE_LAST) begin
              state_d = ST_ALIGNED;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end else begin
              state_d = ST_RSTRT;
              lane_d  = lane_q + LANE_IDX_W'(1);
              retry_d = '0;
              rstrt_d = lane_bit(lane_q + LANE_IDX_W'(1));
              pcnt_d  = PULSE_LAST;
            end
          end
        end
        ST_ALIGNED: ;
        ST_FAIL: ;
        default: state_d = ST_WAIT_LOCK;
      endcase
    end
  end

  assign BIT_ALGN_RSTRT = rstrt_q;
  assign BIT_ALGN_HOLD  = hold_q;
  assign LANE_OK        = ok_q;
  assign ACTIVE_LANE    = lane_q;
  assign ALIGN_BUSY     = busy_q;
  assign ALIGN_DONE     = done_q;
  assign ALIGN_FAIL     = fail_q;
  assign FAIL_LANE      = fail_lane_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_rxiod_lane_align_sequencer.sv
// Directed bench for rxiod_lane_align_sequencer with a behavioural bit-align
// core per lane; pulse order, widths and spacing are logged and checked.
module tb_rxiod_lane_align_sequencer;

  localparam int NL  = 4;
  localparam int TO  = 200;
  localparam int DLY = 100;
  localparam int PW  = 4;

  logic          SCLK = 1'b0;
  logic          RESETN = 1'b0;
  logic          PLL_LOCK = 1'b0;
  logic          TRAIN_REQ = 1'b0;
  logic [NL-1:0] BIT_ALGN_DONE, BIT_ALGN_ERR, BIT_ALGN_OOR;
  logic [NL-1:0] BIT_ALGN_RSTRT, BIT_ALGN_HOLD, LANE_OK;
  logic [1:0]    ACTIVE_LANE, FAIL_LANE;
  logic          ALIGN_BUSY, ALIGN_DONE, ALIGN_FAIL;
  logic [2:0]    state_dbg;

  rxiod_lane_align_sequencer #(
    .NUM_LANES(NL), .LANE_IDX_W(2), .TIMEOUT_W(16), .TIMEOUT_CYC(TO),
    .MAX_RETRY(3), .RSTRT_PULSE(PW)
  ) dut (
    .SCLK(SCLK), .RESETN(RESETN), .PLL_LOCK(PLL_LOCK), .TRAIN_REQ(TRAIN_REQ),
    .BIT_ALGN_DONE(BIT_ALGN_DONE), .BIT_ALGN_ERR(BIT_ALGN_ERR),
    .BIT_ALGN_OOR(BIT_ALGN_OOR), .BIT_ALGN_RSTRT(BIT_ALGN_RSTRT),
    .BIT_ALGN_HOLD(BIT_ALGN_HOLD), .LANE_OK(LANE_OK), .ACTIVE_LANE(ACTIVE_LANE),
    .ALIGN_BUSY(ALIGN_BUSY), .ALIGN_DONE(ALIGN_DONE), .ALIGN_FAIL(ALIGN_FAIL),
    .FAIL_LANE(FAIL_LANE), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 SCLK = ~SCLK;

  // lane core configuration (written by the stimulus)
  int            bad_n[NL];
  int            att_base[NL];
  logic [NL-1:0] oor_v = '0;
  logic [NL-1:0] stuck_v = '0;
  logic [NL-1:0] stale_v = '0;

  // lane core state and pulse log (written by the model)
  logic [NL-1:0] done_r = '0;
  logic [NL-1:0] err_r = '0;
  logic [NL-1:0] oor_r = '0;
  int            cnt[NL];
  int            attempt_no[NL];
  int            width_cur[NL];
  bit            in_train[NL];
  int            cyc = 0;
  bit            multi_hot = 1'b0;
  logic [1:0]    start_log[$];
  int            start_cyc[$];
  int            width_log[$];

  assign BIT_ALGN_DONE = done_r | stale_v;
  assign BIT_ALGN_ERR  = err_r;
  assign BIT_ALGN_OOR  = oor_r;

  initial begin
    for (int i = 0; i < NL; i++) begin
      cnt[i] = 0; attempt_no[i] = 0; width_cur[i] = 0; in_train[i] = 1'b0;
    end
  end

  always @(negedge SCLK) begin
    cyc = cyc + 1;
    if ($countones(BIT_ALGN_RSTRT) > 1) multi_hot = 1'b1;
    for (int i = 0; i < NL; i++) begin
      if (BIT_ALGN_RSTRT[i] === 1'b1) begin
        if (width_cur[i] == 0) begin
          attempt_no[i] = attempt_no[i] + 1;
          start_log.push_back(2'(i));
          start_cyc.push_back(cyc);
        end
        width_cur[i] = width_cur[i] + 1;
        in_train[i] = 1'b1;
        cnt[i] = 0;
        done_r[i] = 1'b0; err_r[i] = 1'b0; oor_r[i] = 1'b0;
      end else begin
        if (width_cur[i] != 0) begin
          width_log.push_back(width_cur[i]);
          width_cur[i] = 0;
        end
        if (in_train[i]) begin
          cnt[i] = cnt[i] + 1;
          if (cnt[i] == DLY) begin
            in_train[i] = 1'b0;
            if (!stuck_v[i] && !stale_v[i]) begin
              done_r[i] = 1'b1;
              if ((attempt_no[i] - att_base[i]) <= bad_n[i]) begin
                if (oor_v[i]) oor_r[i] = 1'b1;
                else          err_r[i] = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  // scoreboard
  int         n_checks = 0;
  int         n_fail = 0;
  int         rd_ptr = 0;
  logic [1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge SCLK);
  endtask

  task automatic cfg(input int lane, input int nbad, input bit oor, input bit stk, input bit stl);
    bad_n[lane] = nbad;
    att_base[lane] = attempt_no[lane];
    oor_v[lane] = oor;
    stuck_v[lane] = stk;
    stale_v[lane] = stl;
  endtask

  task automatic cfg_all_pass();
    for (int i = 0; i < NL; i++) cfg(i, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_end(input string tag, input int budget);
    int k = 0;
    while (!(ALIGN_DONE || ALIGN_FAIL) && k < budget) begin
      @(negedge SCLK);
      k++;
    end
    chk({tag, "_bound"}, 32'(k < budget), 1);
  endtask

  task automatic chk_pulses(input string tag);
    int n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      logic [1:0] e = exp_q.pop_front();
      if (rd_ptr < start_log.size()) begin
        chk({tag, "_lane"}, 32'(start_log[rd_ptr]), 32'(e));
        chk({tag, "_width"}, width_log[rd_ptr], PW);
      end else begin
        chk({tag, "_missing"}, 32'hdead, 32'(e));
      end
      rd_ptr++;
    end
    chk({tag, "_count"}, start_log.size(), rd_ptr);
  endtask

  task automatic chk_gap(input string tag, input int idx, input int exp);
    chk(tag, start_cyc[idx+1] - start_cyc[idx], exp);
  endtask

  task automatic pulse_train_req();
    TRAIN_REQ = 1'b1;
    tick(1);
    TRAIN_REQ = 1'b0;
  endtask

  initial begin
    int base;
    int k;
    cfg_all_pass();

    // reset
    tick(5);
    chk("rst_rstrt", BIT_ALGN_RSTRT, 0);
    chk("rst_hold", BIT_ALGN_HOLD, 0);
    chk("rst_ok", LANE_OK, 0);
    chk("rst_busy", ALIGN_BUSY, 0);
    chk("rst_done", ALIGN_DONE, 0);
    chk("rst_fail", ALIGN_FAIL, 0);
    chk("rst_state", state_dbg, 0);
    RESETN = 1'b1;
    tick(3);
    chk("nolock_busy", ALIGN_BUSY, 0);
    chk("nolock_rstrt", BIT_ALGN_RSTRT, 0);

    // nominal: four lanes pass in order
    base = rd_ptr;
    PLL_LOCK = 1'b1;
    tick(1);
    chk("nom_rstrt0", BIT_ALGN_RSTRT, 4'b0001);
    chk("nom_busy", ALIGN_BUSY, 1);
    chk("nom_active", ACTIVE_LANE, 0);
    chk("nom_state_rstrt", state_dbg, 1);
    tick(3);
    chk("nom_rstrt_last", BIT_ALGN_RSTRT, 4'b0001);
    tick(1);
    chk("nom_rstrt_end", BIT_ALGN_RSTRT, 4'b0000);
    chk("nom_state_wait", state_dbg, 2);
    wait_end("nom", 2000);
    chk("nom_done", ALIGN_DONE, 1);
    chk("nom_fail", ALIGN_FAIL, 0);
    chk("nom_ok", LANE_OK, 4'b1111);
    chk("nom_hold", BIT_ALGN_HOLD, 4'b1111);
    chk("nom_busy_end", ALIGN_BUSY, 0);
    chk("nom_state_end", state_dbg, 3);
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3};
    chk_pulses("nom");
    chk_gap("nom_gap_pass", base, PW + DLY);

    // retrain held high; lane 1 ERR+DONE twice, lane 3 OOR+DONE once
    cfg_all_pass();
    cfg(1, 2, 1'b0, 1'b0, 1'b0);
    cfg(3, 1, 1'b1, 1'b0, 1'b0);
    base = rd_ptr;
    TRAIN_REQ = 1'b1;
    tick(1);
    chk("rt_done_clr", ALIGN_DONE, 0);
    chk("rt_hold_clr", BIT_ALGN_HOLD, 0);
    chk("rt_ok_clr", LANE_OK, 0);
    chk("rt_state", state_dbg, 0);
    tick(1);
    chk("rt_restart", BIT_ALGN_RSTRT, 4'b0001);
    tick(998);
    TRAIN_REQ = 1'b0;
    chk("rt_done", ALIGN_DONE, 1);
    chk("rt_ok", LANE_OK, 4'b1111);
    tick(20);
    chk("rt_done_after_fall", ALIGN_DONE, 1);
    chk("rt_state_end", state_dbg, 3);
    exp_q = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3};
    chk_pulses("rt");
    chk_gap("rt_gap_retry", base + 1, PW + DLY);

    // lock loss during lane 1 wait
    cfg_all_pass();
    pulse_train_req();
    k = 0;
    while (!(ALIGN_BUSY && BIT_ALGN_RSTRT == 0 && ACTIVE_LANE == 1) && k < 500) begin
      tick(1);
      k++;
    end
    chk("ll_reach_lane1", 32'(k < 500), 1);
    tick(20);
    PLL_LOCK = 1'b0;
    tick(1);
    chk("ll_rstrt", BIT_ALGN_RSTRT, 0);
    chk("ll_ok", LANE_OK, 0);
    chk("ll_busy", ALIGN_BUSY, 0);
    chk("ll_state", state_dbg, 0);
    tick(5);
    chk("ll_idle", state_dbg, 0);
    PLL_LOCK = 1'b1;
    tick(1);
    chk("ll_relock_rstrt", BIT_ALGN_RSTRT, 4'b0001);
    chk("ll_relock_lane", ACTIVE_LANE, 0);
    wait_end("ll", 2000);
    chk("ll_done", ALIGN_DONE, 1);
    chk("ll_ok_end", LANE_OK, 4'b1111);
    exp_q = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3};
    chk_pulses("ll");

    // lane 2 never completes: four timed-out attempts then FAIL
    cfg_all_pass();
    cfg(2, 0, 1'b0, 1'b1, 1'b0);
    base = rd_ptr;
    pulse_train_req();
    wait_end("to", 3000);
    chk("to_fail", ALIGN_FAIL, 1);
    chk("to_fail_lane", FAIL_LANE, 2);
    chk("to_ok", LANE_OK, 4'b0011);
    chk("to_hold", BIT_ALGN_HOLD, 4'b0011);
    chk("to_done", ALIGN_DONE, 0);
    chk("to_busy", ALIGN_BUSY, 0);
    chk("to_state", state_dbg, 4);
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2};
    chk_pulses("to");
    chk_gap("to_gap_first", base + 2, PW + TO);
    chk_gap("to_gap_last", base + 4, PW + TO);

    // stale DONE on lane 0 is never accepted
    cfg_all_pass();
    cfg(0, 0, 1'b0, 1'b0, 1'b1);
    base = rd_ptr;
    pulse_train_req();
    chk("st_fail_clr", ALIGN_FAIL, 0);
    chk("st_fail_lane_clr", FAIL_LANE, 0);
    chk("st_ok_clr", LANE_OK, 0);
    wait_end("st", 3000);
    chk("st_fail", ALIGN_FAIL, 1);
    chk("st_fail_lane", FAIL_LANE, 0);
    chk("st_ok", LANE_OK, 0);
    chk("st_hold", BIT_ALGN_HOLD, 0);
    exp_q = '{2'd0, 2'd0, 2'd0, 2'd0};
    chk_pulses("st");
    chk_gap("st_gap", base, PW + TO);

    // reset from FAIL
    RESETN = 1'b0;
    tick(2);
    chk("rst2_fail", ALIGN_FAIL, 0);
    chk("rst2_state", state_dbg, 0);
    chk("rst2_ok", LANE_OK, 0);
    chk("onehot_rstrt", 32'(multi_hot), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rxiod_lane_align_sequencer.md
Name: rxiod_lane_align_sequencer

Overview:
Sequences RX IOD bit-alignment training across NUM_LANES lanes, each served by its own bit-align core, one lane at a time. Waits for PLL lock, restarts each lane's bit-align core, and waits for DONE/ERR/OOR or a timeout. It retries failed lanes, freezes passed lanes, and reports overall aligned or fail status to the video receive pipeline control.

Parameters:
NUM_LANES, 4, number of lanes sequenced (2..8)
LANE_IDX_W, 2, width of lane index (clog2(NUM_LANES))
TIMEOUT_W, 16, width of per-attempt timeout counter
TIMEOUT_CYC, 50000, SCLK cycles allowed per training attempt (< 2^TIMEOUT_W)
MAX_RETRY, 3, retries per lane after first attempt
RSTRT_PULSE, 4, width in SCLK cycles of BIT_ALGN_RSTRT pulse (1..15)

Ports:
SCLK  in  1  system clock; all logic rising-edge
RESETN  in  1  synchronous active-low reset
PLL_LOCK  in  1  receive PLL lock (synchronous to SCLK)
TRAIN_REQ  in  1  retrain request; rising edge acts
BIT_ALGN_DONE  in  NUM_LANES  per-lane alignment done from bit-align cores
BIT_ALGN_ERR  in  NUM_LANES  per-lane alignment error
BIT_ALGN_OOR  in  NUM_LANES  per-lane tap out-of-range
BIT_ALGN_RSTRT  out  NUM_LANES  per-lane training restart pulse
BIT_ALGN_HOLD  out  NUM_LANES  per-lane hold (freeze taps of passed lane)
LANE_OK  out  NUM_LANES  lane passed in current training run
ACTIVE_LANE  out  LANE_IDX_W  lane currently being trained
ALIGN_BUSY  out  1  training in progress
ALIGN_DONE  out  1  all lanes aligned
ALIGN_FAIL  out  1  a lane exhausted retries
FAIL_LANE  out  LANE_IDX_W  index of failing lane (valid while ALIGN_FAIL)

Behaviour:
- Interface: one clock (SCLK); reset (RESETN) is synchronous and active-low.
- Reset: all outputs 0, state WAIT_LOCK, lane=0, retry=0, timer=0, TRAIN_REQ edge register=0.
- All outputs registered.
- States: WAIT_LOCK, RSTRT, WAIT_DONE, ALIGNED, FAIL.
- WAIT_LOCK:
  - Outputs idle (BUSY=0).
  - PLL_LOCK=1 sampled -> lane=0, retry=0 -> RSTRT.
  - BIT_ALGN_RSTRT[0] rises the cycle after lock is sampled.
- RSTRT:
  - BIT_ALGN_RSTRT[lane]=1 for exactly RSTRT_PULSE cycles; other bits 0.
  - ALIGN_BUSY=1; ACTIVE_LANE=lane.
  - Timer and done_seen_low cleared -> WAIT_DONE.
- WAIT_DONE:
  - Timer increments each cycle.
  - done_seen_low set when BIT_ALGN_DONE[lane]=0. DONE is honoured only after done_seen_low, so stale DONE from a prior run is rejected.
  - Fail event: (DONE & done_seen_low & (ERR|OOR)), or ERR alone, or timer==TIMEOUT_CYC-1.
  - ERR wins over simultaneous DONE.
  - Pass event: DONE & done_seen_low & !ERR & !OOR -> LANE_OK[lane]=1, BIT_ALGN_HOLD[lane]=1.
  - After pass: if lane==NUM_LANES-1 -> ALIGNED; else lane+1, retry=0 -> RSTRT.
  - After fail: if retry<MAX_RETRY -> retry+1, RSTRT same lane; else -> FAIL.
- ALIGNED: ALIGN_DONE=1, BUSY=0, HOLD all 1, LANE_OK all 1.
- FAIL: ALIGN_FAIL=1, FAIL_LANE=lane, BUSY=0. Passed lanes keep HOLD/LANE_OK.
- TRAIN_REQ rising edge (registered edge detect) in any state except WAIT_LOCK:
  - Clear LANE_OK, HOLD, DONE, FAIL and RSTRT (an in-flight pulse is truncated).
  - Go to WAIT_LOCK; restarts from lane 0 one cycle later if lock is held.
- PLL_LOCK=0 in any state but WAIT_LOCK: same abort as TRAIN_REQ. Lock loss takes priority if both occur in the same cycle.
- TRAIN_REQ held high: only one retrain per rising edge.
- Retry counter width: clog2(MAX_RETRY+1); no wrap.

Test Plan:
- Nominal, 4 lanes: PLL_LOCK=1 and each lane DONE 0->1 after 100 cycles, ERR=0 -> RSTRT pulses 4 cycles on lanes 0,1,2,3 in order; LANE_OK=4'b1111, HOLD=4'b1111, ALIGN_DONE=1.
- Retry: lane 1 ERR on first two attempts, pass on third -> three RSTRT pulses on lane 1; lane 2 starts with retry=0; ALIGN_DONE=1.
- Timeout fail: lane 2 DONE stuck 0 -> 4 attempts of 50000 cycles each; then ALIGN_FAIL=1, FAIL_LANE=2, LANE_OK=4'b0011.
- Stale DONE: lane 0 DONE held 1 through RSTRT and never drops -> no pass accepted; timeout/retry path taken.
- Lock loss mid-training: PLL_LOCK drops during lane 1 WAIT_DONE -> next cycle RSTRT=0, LANE_OK=0, BUSY=0; relock -> restart at lane 0.
- Retrain: TRAIN_REQ pulse in ALIGNED -> ALIGN_DONE=0, HOLD=0, full sequence repeats. TRAIN_REQ held high 1000 cycles -> only one retrain.
